// File: rtl/liang_pkg.sv
// Shared core types: data/pc widths, functional-unit ops and the
// EX->WB bundle consumed by the writeback stage.
package liang_pkg;

    typedef logic [31:0] ele_t;
    typedef logic [31:0] pc_t;

    typedef enum logic [2:0] {
        ALU,
        LOAD,
        STORE,
        BRANCH,
        JAL,
        JALR,
        CSR,
        EBREAK
    } fu_op_e;

    typedef enum logic {
        RUN,
        HALT
    } wb_state_e;

    typedef struct packed {
        pc_t        pc;
        fu_op_e     fu_op;
        logic [4:0] rd;
        logic       rf_wen;
    } uop_info_t;

    typedef struct packed {
        ele_t      alu_res;
        ele_t      lsu_res;
        uop_info_t uop_info;
        pc_t       dnpc;
    } exToWb_t;

    // Link address for jumps is pc+4 in 32 bits and wraps naturally.
    function automatic ele_t wb_data(input exToWb_t e);
        ele_t w_d;
        unique case (e.uop_info.fu_op)
            LOAD:      w_d = e.lsu_res;
            JAL, JALR: w_d = e.uop_info.pc + 32'd4;
            default:   w_d = e.alu_res;
        endcase
        return w_d;
    endfunction

endpackage

// File: rtl/pipe_wbu.sv
// Writeback stage: one-entry holding register that retires every cycle,
// drives the register-file write port, forwarding and commit info.
module pipe_wbu
    import liang_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ex_valid_i,
    output logic        wb_ready_o,
    input  exToWb_t     exToWb_i,
    output logic        wb_fwd_valid_o,
    output logic [4:0]  wb_fwd_rd_o,
    output ele_t        wb_fwd_data_o,
    output logic        rf_wen_o,
    output logic [4:0]  rf_waddr_o,
    output ele_t        rf_wdata_o,
    output logic        commit_valid_o,
    output pc_t         commit_pc_o,
    output pc_t         commit_dnpc_o,
    output logic [63:0] instret_o,
    output logic        halt_o
);

    logic        r_valid;
    exToWb_t     r_entry;
    wb_state_e   r_state;
    logic        r_halt;
    logic [63:0] r_instret;

    logic        w_retire;
    logic        w_wen;
    ele_t        w_wdata;
    logic [4:0]  w_waddr;

    assign w_retire = r_valid && (r_state == RUN);
    assign w_wen    = w_retire && r_entry.uop_info.rf_wen
                      && (r_entry.uop_info.rd != 5'd0);
    assign w_wdata  = w_wen ? wb_data(r_entry) : '0;
    assign w_waddr  = w_wen ? r_entry.uop_info.rd : 5'd0;

    // The entry drains every RUN cycle, so ready only drops in HALT/reset.
    assign wb_ready_o = !rst_i && (r_state == RUN)
                        && (!r_valid || w_retire);

    assign rf_wen_o       = w_wen;
    assign rf_waddr_o     = w_waddr;
    assign rf_wdata_o     = w_wdata;
    assign wb_fwd_valid_o = w_wen;
    assign wb_fwd_rd_o    = w_waddr;
    assign wb_fwd_data_o  = w_wdata;

    assign commit_valid_o = w_retire;
    assign commit_pc_o    = w_retire ? r_entry.uop_info.pc : '0;
    assign commit_dnpc_o  = w_retire ? r_entry.dnpc : '0;

    assign instret_o = r_instret;
    assign halt_o    = r_halt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid <= 1'b0;
            r_entry <= '0;
        end else if (wb_ready_o) begin
            r_valid <= ex_valid_i;
            if (ex_valid_i)
                r_entry <= exToWb_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            r_instret <= 64'd0;
        else if (w_retire)
            r_instret <= r_instret + 64'd1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= RUN;
            r_halt  <= 1'b0;
        end else begin
            unique case (r_state)
                RUN: begin
                    if (w_retire && r_entry.uop_info.fu_op == EBREAK) begin
                        r_state <= HALT;
                        r_halt  <= 1'b1;
                    end
                end
                HALT: begin
                    r_state <= HALT;
                    r_halt  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_wbu.sv
// Directed bench for pipe_wbu: retire, data select, throughput, halt, reset.
module tb_pipe_wbu;
    import liang_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        ex_valid_i;
    logic        wb_ready_o;
    exToWb_t     exToWb_i;
    logic        wb_fwd_valid_o;
    logic [4:0]  wb_fwd_rd_o;
    ele_t        wb_fwd_data_o;
    logic        rf_wen_o;
    logic [4:0]  rf_waddr_o;
    ele_t        rf_wdata_o;
    logic        commit_valid_o;
    pc_t         commit_pc_o;
    pc_t         commit_dnpc_o;
    logic [63:0] instret_o;
    logic        halt_o;

    int pass = 0;
    int total = 0;

    pipe_wbu dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .ex_valid_i    (ex_valid_i),
        .wb_ready_o    (wb_ready_o),
        .exToWb_i      (exToWb_i),
        .wb_fwd_valid_o(wb_fwd_valid_o),
        .wb_fwd_rd_o   (wb_fwd_rd_o),
        .wb_fwd_data_o (wb_fwd_data_o),
        .rf_wen_o      (rf_wen_o),
        .rf_waddr_o    (rf_waddr_o),
        .rf_wdata_o    (rf_wdata_o),
        .commit_valid_o(commit_valid_o),
        .commit_pc_o   (commit_pc_o),
        .commit_dnpc_o (commit_dnpc_o),
        .instret_o     (instret_o),
        .halt_o        (halt_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic exToWb_t mk(input fu_op_e op, input pc_t pc,
                                   input logic [4:0] rd, input logic wen,
                                   input ele_t alu, input ele_t lsu,
                                   input pc_t dnpc);
        exToWb_t e;
        e.alu_res         = alu;
        e.lsu_res         = lsu;
        e.uop_info.pc     = pc;
        e.uop_info.fu_op  = op;
        e.uop_info.rd     = rd;
        e.uop_info.rf_wen = wen;
        e.dnpc            = dnpc;
        return e;
    endfunction

    // Present one entry for one cycle; returns at the negedge where it retires.
    task automatic drive(input exToWb_t e);
        @(negedge clk_i);
        ex_valid_i = 1'b1;
        exToWb_i   = e;
        @(negedge clk_i);
        ex_valid_i = 1'b0;
        exToWb_i   = '0;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        total++; if (wb_ready_o !== 1'b0) $display("FAIL rst_ready got=%b exp=0", wb_ready_o); else pass++;
        total++; if (commit_valid_o !== 1'b0) $display("FAIL rst_commit got=%b exp=0", commit_valid_o); else pass++;
        total++; if (rf_wen_o !== 1'b0) $display("FAIL rst_wen got=%b exp=0", rf_wen_o); else pass++;
        total++; if (instret_o !== 64'd0) $display("FAIL rst_instret got=%h exp=0", instret_o); else pass++;
        total++; if (halt_o !== 1'b0) $display("FAIL rst_halt got=%b exp=0", halt_o); else pass++;
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        total++; if (wb_ready_o !== 1'b1) $display("FAIL rst_ready_after got=%b exp=1", wb_ready_o); else pass++;
    endtask

    task automatic test_addi();
        drive(mk(ALU, 32'h8000_0000, 5'd5, 1'b1, 32'h10, 32'h0, 32'h8000_0004));
        total++; if (rf_wen_o !== 1'b1) $display("FAIL addi_wen got=%b exp=1", rf_wen_o); else pass++;
        total++; if (rf_waddr_o !== 5'd5) $display("FAIL addi_waddr got=%0d exp=5", rf_waddr_o); else pass++;
        total++; if (rf_wdata_o !== 32'h10) $display("FAIL addi_wdata got=%h exp=10", rf_wdata_o); else pass++;
        total++; if (wb_fwd_valid_o !== 1'b1) $display("FAIL addi_fwd_valid got=%b exp=1", wb_fwd_valid_o); else pass++;
        total++; if (wb_fwd_rd_o !== 5'd5) $display("FAIL addi_fwd_rd got=%0d exp=5", wb_fwd_rd_o); else pass++;
        total++; if (wb_fwd_data_o !== 32'h10) $display("FAIL addi_fwd_data got=%h exp=10", wb_fwd_data_o); else pass++;
        total++; if (commit_valid_o !== 1'b1) $display("FAIL addi_commit got=%b exp=1", commit_valid_o); else pass++;
        total++; if (instret_o !== 64'd0) $display("FAIL addi_instret0 got=%0d exp=0", instret_o); else pass++;
        @(negedge clk_i);
        total++; if (instret_o !== 64'd1) $display("FAIL addi_instret1 got=%0d exp=1", instret_o); else pass++;
        total++; if (commit_valid_o !== 1'b0) $display("FAIL addi_drain got=%b exp=0", commit_valid_o); else pass++;
    endtask

    task automatic test_jal();
        drive(mk(JAL, 32'h8000_0010, 5'd1, 1'b1, 32'h1234, 32'h0, 32'h8000_0200));
        total++; if (rf_wdata_o !== 32'h8000_0014) $display("FAIL jal_wdata got=%h exp=80000014", rf_wdata_o); else pass++;
        total++; if (rf_waddr_o !== 5'd1) $display("FAIL jal_waddr got=%0d exp=1", rf_waddr_o); else pass++;
        total++; if (commit_pc_o !== 32'h8000_0010) $display("FAIL jal_pc got=%h exp=80000010", commit_pc_o); else pass++;
        total++; if (commit_dnpc_o !== 32'h8000_0200) $display("FAIL jal_dnpc got=%h exp=80000200", commit_dnpc_o); else pass++;
        drive(mk(JALR, 32'hFFFF_FFFC, 5'd2, 1'b1, 32'h5, 32'h0, 32'h0000_0040));
        total++; if (rf_wdata_o !== 32'h0) $display("FAIL jalr_wrap got=%h exp=0", rf_wdata_o); else pass++;
    endtask

    task automatic test_load();
        drive(mk(LOAD, 32'h8000_0020, 5'd0, 1'b1, 32'h11, 32'hDEAD_BEEF, 32'h8000_0024));
        total++; if (commit_valid_o !== 1'b1) $display("FAIL ldx0_commit got=%b exp=1", commit_valid_o); else pass++;
        total++; if (rf_wen_o !== 1'b0) $display("FAIL ldx0_wen got=%b exp=0", rf_wen_o); else pass++;
        total++; if (wb_fwd_valid_o !== 1'b0) $display("FAIL ldx0_fwd got=%b exp=0", wb_fwd_valid_o); else pass++;
        drive(mk(LOAD, 32'h8000_0024, 5'd3, 1'b1, 32'h11, 32'hDEAD_BEEF, 32'h8000_0028));
        total++; if (rf_wdata_o !== 32'hDEAD_BEEF) $display("FAIL ld_wdata got=%h exp=deadbeef", rf_wdata_o); else pass++;
    endtask

    task automatic test_idle();
        @(negedge clk_i);
        total++; if (commit_valid_o !== 1'b0) $display("FAIL idle_commit got=%b exp=0", commit_valid_o); else pass++;
        total++; if (rf_wen_o !== 1'b0) $display("FAIL idle_wen got=%b exp=0", rf_wen_o); else pass++;
        total++; if (commit_pc_o !== 32'h0) $display("FAIL idle_pc got=%h exp=0", commit_pc_o); else pass++;
        total++; if (wb_ready_o !== 1'b1) $display("FAIL idle_ready got=%b exp=1", wb_ready_o); else pass++;
    endtask

    task automatic test_back_to_back();
        int ncommit = 0;
        do_reset();
        @(negedge clk_i);
        for (int i = 0; i <= 8; i++) begin
            if (i > 0) begin
                if (commit_valid_o === 1'b1) ncommit++;
                total++;
                if (commit_pc_o !== 32'h1000 + 32'(4 * (i - 1)))
                    $display("FAIL b2b_pc%0d got=%h exp=%h", i - 1, commit_pc_o, 32'h1000 + 32'(4 * (i - 1)));
                else pass++;
            end
            if (i < 8) begin
                total++; if (wb_ready_o !== 1'b1) $display("FAIL b2b_ready%0d got=%b exp=1", i, wb_ready_o); else pass++;
                ex_valid_i = 1'b1;
                exToWb_i   = mk(ALU, 32'h1000 + 32'(4 * i), 5'(i + 1), 1'b1, 32'(3 * i), 32'h0, 32'h1004 + 32'(4 * i));
                @(negedge clk_i);
            end else begin
                ex_valid_i = 1'b0;
                exToWb_i   = '0;
            end
        end
        total++; if (ncommit != 8) $display("FAIL b2b_commits got=%0d exp=8", ncommit); else pass++;
        @(negedge clk_i);
        total++; if (instret_o !== 64'd8) $display("FAIL b2b_instret got=%0d exp=8", instret_o); else pass++;
    endtask

    task automatic test_instret_wrap();
        @(negedge clk_i);
        force dut.r_instret = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk_i);
        release dut.r_instret;
        total++; if (instret_o !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL wrap_preload got=%h exp=ffffffffffffffff", instret_o); else pass++;
        drive(mk(ALU, 32'h3000, 5'd4, 1'b1, 32'h1, 32'h0, 32'h3004));
        @(negedge clk_i);
        total++; if (instret_o !== 64'd0) $display("FAIL wrap_instret got=%h exp=0", instret_o); else pass++;
    endtask

    task automatic test_reset_mid();
        drive(mk(ALU, 32'h3100, 5'd6, 1'b1, 32'h6, 32'h0, 32'h3104));
        @(negedge clk_i);
        ex_valid_i = 1'b1;
        exToWb_i   = mk(ALU, 32'h3200, 5'd9, 1'b1, 32'h99, 32'h0, 32'h3204);
        @(posedge clk_i);
        #2;
        rst_i      = 1'b1;
        ex_valid_i = 1'b0;
        exToWb_i   = '0;
        #1;
        total++; if (rf_wen_o !== 1'b0) $display("FAIL rmid_wen got=%b exp=0", rf_wen_o); else pass++;
        total++; if (commit_valid_o !== 1'b0) $display("FAIL rmid_commit got=%b exp=0", commit_valid_o); else pass++;
        total++; if (rf_wdata_o !== 32'h0) $display("FAIL rmid_wdata got=%h exp=0", rf_wdata_o); else pass++;
        total++; if (wb_ready_o !== 1'b0) $display("FAIL rmid_ready got=%b exp=0", wb_ready_o); else pass++;
        total++; if (instret_o !== 64'd0) $display("FAIL rmid_instret got=%0d exp=0", instret_o); else pass++;
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        total++; if (commit_valid_o !== 1'b0) $display("FAIL rmid_stale got=%b exp=0", commit_valid_o); else pass++;
        total++; if (instret_o !== 64'd0) $display("FAIL rmid_instret2 got=%0d exp=0", instret_o); else pass++;
    endtask

    task automatic test_halt();
        @(negedge clk_i);
        ex_valid_i = 1'b1;
        exToWb_i   = mk(EBREAK, 32'h2000, 5'd0, 1'b0, 32'h0, 32'h0, 32'h2004);
        @(negedge clk_i);
        total++; if (commit_valid_o !== 1'b1) $display("FAIL ebrk_commit got=%b exp=1", commit_valid_o); else pass++;
        total++; if (commit_pc_o !== 32'h2000) $display("FAIL ebrk_pc got=%h exp=2000", commit_pc_o); else pass++;
        total++; if (halt_o !== 1'b0) $display("FAIL ebrk_halt_early got=%b exp=0", halt_o); else pass++;
        exToWb_i = mk(ALU, 32'h2004, 5'd7, 1'b1, 32'h77, 32'h0, 32'h2008);
        @(negedge clk_i);
        total++; if (halt_o !== 1'b1) $display("FAIL halt got=%b exp=1", halt_o); else pass++;
        total++; if (wb_ready_o !== 1'b0) $display("FAIL halt_ready got=%b exp=0", wb_ready_o); else pass++;
        total++; if (commit_valid_o !== 1'b0) $display("FAIL halt_commit got=%b exp=0", commit_valid_o); else pass++;
        total++; if (rf_wen_o !== 1'b0) $display("FAIL halt_wen got=%b exp=0", rf_wen_o); else pass++;
        total++; if (instret_o !== 64'd1) $display("FAIL halt_instret got=%0d exp=1", instret_o); else pass++;
        ex_valid_i = 1'b0;
        exToWb_i   = '0;
        repeat (3) @(negedge clk_i);
        total++; if (instret_o !== 64'd1) $display("FAIL halt_frozen got=%0d exp=1", instret_o); else pass++;
        total++; if (wb_fwd_valid_o !== 1'b0) $display("FAIL halt_fwd got=%b exp=0", wb_fwd_valid_o); else pass++;
        total++; if (halt_o !== 1'b1) $display("FAIL halt_sticky got=%b exp=1", halt_o); else pass++;
        do_reset();
        #1;
        total++; if (halt_o !== 1'b0) $display("FAIL unhalt got=%b exp=0", halt_o); else pass++;
        total++; if (wb_ready_o !== 1'b1) $display("FAIL unhalt_ready got=%b exp=1", wb_ready_o); else pass++;
    endtask

    initial begin
        rst_i      = 1'b1;
        ex_valid_i = 1'b0;
        exToWb_i   = '0;
        test_reset();
        test_addi();
        test_jal();
        test_load();
        test_idle();
        test_back_to_back();
        test_instret_wrap();
        test_reset_mid();
        test_halt();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule

// File: doc/pipe_wbu.md
PIPE_WBU -- requirements
Module: pipe_wbu

Interface
REQ-001 SHALL have port clk_i  in  1  rising-edge clock.
REQ-002 SHALL have port rst_i  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have port ex_valid_i  in  1  EX result valid.
REQ-004 SHALL have port wb_ready_o  out  1  WB can accept the EX result.
REQ-005 SHALL have port exToWb_i  in  exToWb_t  fields alu_res, lsu_res, uop_info, dnpc.
REQ-006 SHALL have port wb_fwd_valid_o  out  1  forward valid toward EX.
REQ-007 SHALL have port wb_fwd_rd_o  out  5  forwarded destination register.
REQ-008 SHALL have port wb_fwd_data_o  out  ele_t  forwarded data.
REQ-009 SHALL have port rf_wen_o  out  1  register-file write enable.
REQ-010 SHALL have port rf_waddr_o  out  5  register-file write address.
REQ-011 SHALL have port rf_wdata_o  out  ele_t  register-file write data.
REQ-012 SHALL have port commit_valid_o  out  1  one instruction retires this cycle.
REQ-013 SHALL have port commit_pc_o  out  pc_t  pc of the retiring instruction.
REQ-014 SHALL have port commit_dnpc_o  out  pc_t  next pc of the retiring instruction.
REQ-015 SHALL have port instret_o  out  64  count of retired instructions.
REQ-016 SHALL have port halt_o  out  1  an ebreak has retired; the core is halted.

Function
REQ-017 SHALL hold one entry in a register: wb_valid_q plus exToWb_q.
REQ-018 SHALL capture the input when ex_valid_i && wb_ready_o.
- Effective one cycle after the handshake.
REQ-019 SHALL drive wb_ready_o = (state==RUN) && (!wb_valid_q || retire).
- retire = wb_valid_q && state==RUN; the entry always drains in one cycle.
- Result: back-to-back acceptance at full throughput.
REQ-020 SHALL select write data as follows:
- fu_op==LOAD: lsu_res.
- fu_op in {JAL, JALR}: uop_info.pc+4 (32-bit, wraps modulo 2^32).
- Otherwise: alu_res.
REQ-021 SHALL assert rf_wen_o = retire && uop_info.rf_wen && uop_info.rd!=0.
- x0 is never written.
REQ-022 SHALL drive the forwarding outputs equal to rf_wen_o/rf_waddr_o/rf_wdata_o in the same cycle (combinational).
REQ-023 SHALL assert commit_valid_o = retire.
- commit_pc_o = uop_info.pc; commit_dnpc_o = exToWb_q.dnpc.
REQ-024 SHALL increment instret_o by 1 on every retire.
- 64-bit; wraps from all-ones to 0.
REQ-025 SHALL implement an FSM with states RUN and HALT.
- RUN->HALT when an instruction with fu_op==EBREAK retires; that ebreak still commits and counts.
- HALT is absorbing until reset; halt_o = (state==HALT).
REQ-026 SHALL, in HALT, hold wb_ready_o=0 and all commit/forward/write outputs at 0.
- instret_o is frozen in HALT.
REQ-027 SHALL ignore flush.
- WB holds the oldest instruction; the EX flush never kills it.
REQ-028 SHALL assert no output other than instret_o/halt_o when wb_valid_q==0.

Reset
REQ-029 SHALL, on rst_i assertion (asynchronous), clear wb_valid_q, exToWb_q, instret_o and halt_o to 0 and set state=RUN.
REQ-030 SHALL discard an entry held when reset asserts mid-operation: no commit, no register-file write.
REQ-031 SHALL reset all outputs to 0, except wb_ready_o=1 once rst_i deasserts.

Structure
REQ-032 SHALL take exToWb_t, uop_info_t, ele_t, pc_t and fu_op encodings (LOAD, JAL, JALR, EBREAK) from liang_pkg.
- A new enum wb_state_e {RUN, HALT} SHALL be added to liang_pkg.
REQ-033 SHALL be a single module without sub-modules.
- The register file stays external.

Verification
REQ-034 ADDI to x5 with alu_res=0x10, rf_wen=1 -> next cycle: rf_wen_o=1, rf_waddr_o=5, rf_wdata_o=0x10, wb_fwd_* identical, instret_o 0->1.
REQ-035 JAL with pc=0x80000010, rd=1 -> rf_wdata_o=0x80000014, commit_dnpc_o=exToWb_i.dnpc.
REQ-036 LOAD to rd=0, lsu_res=0xDEADBEEF -> commit_valid_o=1, rf_wen_o=0.
REQ-037 ex_valid_i held high for 8 cycles -> wb_ready_o stays 1, 8 commits on consecutive cycles, instret_o=8.
REQ-038 EBREAK followed by ADDI -> ebreak commits, halt_o=1 the next cycle, wb_ready_o=0, ADDI never commits, instret_o stops at 1.
REQ-039 instret_o preloaded near all-ones (0xFFFFFFFF_FFFFFFFF), one retire -> instret_o=0.
- Separately: rst_i asserted with wb_valid_q=1 -> no rf_wen_o pulse, all outputs 0.
